// File: rtl/stream_negate_engine.sv
// stream_negate_engine
//   Walks a block of MEM_WIDTH beats starting at base_addr. Each beat is
//   loaded over the tagged memory bus and negated (two's complement) in place
//   NEG_LANES integers per cycle. The result is then stored back to the same
//   address. Only one memory transaction is in flight at a time.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   start               begin an operation (sampled only in IDLE)
//   base_addr           first byte address, captured on start
//   num_beats           number of beats to process, captured on start
//   busy                high from the cycle after an accepted start until done
//   done                one-cycle pulse in the final cycle of an operation
//   mem2proc_response   0 = command refused, else tag assigned to the command
//   mem2proc_data       load return data
//   mem2proc_tag        0 = no completion, else tag of the completing access
//   proc2mem_command    0 NONE, 1 LOAD, 2 STORE (registered)
//   proc2mem_address    request address, 0 when no command
//   proc2mem_data       store data, 0 unless STORE
module stream_negate_engine #(
  parameter int MEM_WIDTH  = 64,
  parameter int INT_WIDTH  = 32,
  parameter int NEG_LANES  = 1,
  parameter int ADDR_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_beats,
  output logic                  busy,
  output logic                  done,
  input  logic [3:0]            mem2proc_response,
  input  logic [MEM_WIDTH-1:0]  mem2proc_data,
  input  logic [3:0]            mem2proc_tag,
  output logic [1:0]            proc2mem_command,
  output logic [ADDR_WIDTH-1:0] proc2mem_address,
  output logic [MEM_WIDTH-1:0]  proc2mem_data
);

  localparam int LANES  = MEM_WIDTH / INT_WIDTH;
  localparam int LIDX_W = $clog2(LANES + 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(MEM_WIDTH / 8);

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic [2:0] {
    IDLE, LD_REQ, LD_WAIT, NEG, ST_REQ, ST_WAIT, FIN
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_next;
  logic [CNT_WIDTH-1:0]  remaining, remaining_next;
  logic [3:0]            saved_tag, saved_tag_next;
  logic [MEM_WIDTH-1:0]  beat_buf, beat_buf_next;
  logic [LIDX_W-1:0]     lane_idx, lane_idx_next;
  logic                  tag_hit;

  // Tag 0 means "no completion". It can never match, because only nonzero
  // response tags are ever saved.
  assign tag_hit = (mem2proc_tag != 4'd0) && (mem2proc_tag == saved_tag);

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_next     = state;
    cur_addr_next  = cur_addr;
    remaining_next = remaining;
    saved_tag_next = saved_tag;
    beat_buf_next  = beat_buf;
    lane_idx_next  = lane_idx;

    case (state)
      IDLE: begin
        if (start) begin
          cur_addr_next  = base_addr;
          remaining_next = num_beats;
          state_next     = (num_beats == '0) ? FIN : LD_REQ;
        end
      end
      LD_REQ: begin
        if (mem2proc_response != 4'd0) begin
          saved_tag_next = mem2proc_response;
          state_next     = LD_WAIT;
        end
      end
      LD_WAIT: begin
        if (tag_hit) begin
          beat_buf_next = mem2proc_data;
          lane_idx_next = '0;
          state_next    = NEG;
        end
      end
      NEG: begin
        // Negate the window of lanes starting at lane_idx. Negation is
        // modulo 2^INT_WIDTH, so the most negative value maps to itself.
        for (int i = 0; i < LANES; i++) begin
          if (i >= int'(lane_idx) && i < int'(lane_idx) + NEG_LANES)
            beat_buf_next[i*INT_WIDTH +: INT_WIDTH] = -beat_buf[i*INT_WIDTH +: INT_WIDTH];
        end
        lane_idx_next = lane_idx + LIDX_W'(NEG_LANES);
        if (int'(lane_idx) + NEG_LANES >= LANES)
          state_next = ST_REQ;
      end
      ST_REQ: begin
        if (mem2proc_response != 4'd0) begin
          saved_tag_next = mem2proc_response;
          state_next     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tag_hit) begin
          cur_addr_next  = cur_addr + BEAT_BYTES;
          remaining_next = remaining - 1'b1;
          state_next     = (remaining == CNT_WIDTH'(1)) ? FIN : LD_REQ;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The bus outputs are registered from the next-state values. As a result
  // they change only on a state transition and stay steady during retries.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples the values from before the edge.
    if (reset) begin
      // NOTE: the beat buffer is a plain register, not a RAM, so it is
      // cleared along with everything else.
      state            <= IDLE;
      cur_addr         <= '0;
      remaining        <= '0;
      saved_tag        <= '0;
      beat_buf         <= '0;
      lane_idx         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      proc2mem_command <= CMD_NONE;
      proc2mem_address <= '0;
      proc2mem_data    <= '0;
    end else begin
      state     <= state_next;
      cur_addr  <= cur_addr_next;
      remaining <= remaining_next;
      saved_tag <= saved_tag_next;
      beat_buf  <= beat_buf_next;
      lane_idx  <= lane_idx_next;
      busy      <= (state_next != IDLE) && (state_next != FIN);
      done      <= (state_next == FIN);
      case (state_next)
        LD_REQ: begin
          proc2mem_command <= CMD_LOAD;
          proc2mem_address <= cur_addr_next;
          proc2mem_data    <= '0;
        end
        ST_REQ: begin
          proc2mem_command <= CMD_STORE;
          proc2mem_address <= cur_addr_next;
          proc2mem_data    <= beat_buf_next;
        end
        default: begin
          proc2mem_command <= CMD_NONE;
          proc2mem_address <= '0;
          proc2mem_data    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_negate_engine.sv
// Bench for stream_negate_engine. dut_a uses NEG_LANES=1 and dut_b uses
// NEG_LANES=2. Both share the memory-side inputs, and start is steered to
// one DUT at a time. A procedural memory model accepts requests and returns
// completions. Expected bus transactions go into a scoreboard queue when an
// operation is launched and are popped as the DUT issues them.
module tb_stream_negate_engine;
  localparam int MW = 64;
  localparam int IW = 32;
  localparam int AW = 64;
  localparam int CW = 16;
  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;

  typedef struct packed {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [MW-1:0] data;
  } txn_t;

  logic          clock = 1'b0;
  logic          reset, start, sel;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_beats;
  logic [3:0]    resp, tag_in;
  logic [MW-1:0] rdata;
  logic          start_a, start_b;
  logic          busy_a, done_a, busy_b, done_b;
  logic [1:0]    cmd_a, cmd_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [MW-1:0] data_a, data_b;
  logic          busy, done;
  logic [1:0]    cmd;
  logic [AW-1:0] addr;
  logic [MW-1:0] data;

  int   n_checks = 0;
  int   n_fail   = 0;
  txn_t exp_q[$];
  logic [MW-1:0] mem [logic [AW-1:0]];
  int   last_neg, last_cycles;
  logic [AW-1:0] last_ld_addr;

  always #5 clock = ~clock;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  always_comb begin
    busy = sel ? busy_b : busy_a;
    done = sel ? done_b : done_a;
    cmd  = sel ? cmd_b  : cmd_a;
    addr = sel ? addr_b : addr_a;
    data = sel ? data_b : data_a;
  end

  stream_negate_engine #(.MEM_WIDTH(MW), .INT_WIDTH(IW), .NEG_LANES(1),
                         .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .base_addr(base_addr),
    .num_beats(num_beats), .busy(busy_a), .done(done_a),
    .mem2proc_response(resp), .mem2proc_data(rdata), .mem2proc_tag(tag_in),
    .proc2mem_command(cmd_a), .proc2mem_address(addr_a), .proc2mem_data(data_a));

  stream_negate_engine #(.MEM_WIDTH(MW), .INT_WIDTH(IW), .NEG_LANES(2),
                         .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .base_addr(base_addr),
    .num_beats(num_beats), .busy(busy_b), .done(done_b),
    .mem2proc_response(resp), .mem2proc_data(rdata), .mem2proc_tag(tag_in),
    .proc2mem_command(cmd_b), .proc2mem_address(addr_b), .proc2mem_data(data_b));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] neg_beat(input logic [MW-1:0] v);
    logic [MW-1:0] r;
    for (int k = 0; k < MW / IW; k++) r[k*IW +: IW] = 32'd0 - v[k*IW +: IW];
    return r;
  endfunction

  // Runs one operation on the DUT chosen by sel. Arguments:
  //   retries  number of times the first LOAD is refused
  //   lat      completion latency in cycles after acceptance
  //   stray    send a non-matching tag 7 one cycle before a LOAD completes
  //   abort    pulse reset once the first STORE has been accepted
  task automatic run_op(input logic [AW-1:0] base, input int n, input int retries,
                        input int lat, input bit stray, input logic [3:0] tag,
                        input bit abort);
    logic [AW-1:0] a;
    txn_t cur, e;
    int   cycles = 0, accepts = 0, countdown = 0, retry_left = retries;
    int   hold_cnt = 0, hold_bad = 0, neg_mark = 0;
    bit   outstanding = 0, saw_done = 0, busy_ok = 1, cmd_in_wait = 0, first_acc = 0;
    bit   idle_ok = 1;
    logic [1:0] hcmd = C_NONE;
    logic [AW-1:0] haddr = '0;

    for (int b = 0; b < n; b++) begin
      a = base + AW'(8 * b);
      if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
      exp_q.push_back('{cmd: C_LOAD,  addr: a, data: '0});
      exp_q.push_back('{cmd: C_STORE, addr: a, data: neg_beat(mem[a])});
    end

    @(negedge clock);
    base_addr = base; num_beats = CW'(n); start = 1'b1;
    while (cycles < 500) begin
      @(negedge clock);
      start = 1'b0; resp = 4'd0; tag_in = 4'd0; rdata = '0;
      cycles++;
      if (done) begin
        saw_done = 1;
        check("busy_in_fin", busy, 1'b0);
        check("cmd_in_fin", cmd, C_NONE);
        break;
      end
      if (!busy) busy_ok = 0;
      if (outstanding) begin
        if (cmd != C_NONE) cmd_in_wait = 1;
        countdown--;
        if (stray && countdown == 1 && cur.cmd == C_LOAD) tag_in = 4'd7;
        if (countdown == 0) begin
          tag_in = tag;
          outstanding = 0;
          if (cur.cmd == C_LOAD) begin
            rdata = mem[cur.addr];
            neg_mark = cycles;
          end else begin
            mem[cur.addr] = cur.data;
          end
        end
      end else if (cmd != C_NONE) begin
        if (!first_acc) begin
          if (hold_cnt == 0) begin hcmd = cmd; haddr = addr; end
          else if (cmd !== hcmd || addr !== haddr) hold_bad++;
          hold_cnt++;
        end
        if (retry_left > 0) begin
          retry_left--;
        end else begin
          first_acc = 1;
          resp = tag;
          accepts++;
          cur = '{cmd: cmd, addr: addr, data: data};
          if (cmd == C_LOAD) last_ld_addr = addr;
          if (exp_q.size() == 0) begin
            check("sb_unexpected_cmd", cmd, C_NONE);
          end else begin
            e = exp_q.pop_front();
            check("sb_cmd", cmd, e.cmd);
            check("sb_addr", addr, e.addr);
            check("sb_data", data, e.data);
          end
          if (cmd == C_STORE) last_neg = cycles - neg_mark;
          outstanding = 1;
          countdown = lat;
          if (abort && cmd == C_STORE) begin
            @(negedge clock);
            resp = 4'd0; reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_cmd", cmd, C_NONE);
            tag_in = tag;  // late completion for the aborted store
            repeat (4) begin
              @(negedge clock);
              tag_in = 4'd0;
              if (busy || done || cmd != C_NONE) idle_ok = 0;
            end
            check("rst_late_tag_ignored", idle_ok, 1'b1);
            exp_q.delete();
            return;
          end
        end
      end
    end
    last_cycles = cycles;
    check("op_done_seen", saw_done, 1'b1);
    check("sb_empty", exp_q.size(), 0);
    check("accept_count", accepts, 2 * n);
    check("busy_until_done", busy_ok, 1'b1);
    check("no_cmd_in_wait", cmd_in_wait, 1'b0);
    if (retries > 0) begin
      check("ld_hold_cycles", hold_cnt, retries + 1);
      check("ld_hold_stable", hold_bad, 0);
    end
    @(negedge clock);
    check("done_single_pulse", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sel = 1'b0; base_addr = '0; num_beats = '0;
    resp = 4'd0; tag_in = 4'd0; rdata = '0;
    last_neg = 0; last_cycles = 0; last_ld_addr = '1;
    repeat (2) @(negedge clock);
    check("reset_busy_a", busy_a, 1'b0);
    check("reset_done_a", done_a, 1'b0);
    check("reset_cmd_a", cmd_a, C_NONE);
    check("reset_addr_a", addr_a, 64'd0);
    check("reset_data_a", data_a, 64'd0);
    check("reset_cmd_b", cmd_b, C_NONE);
    reset = 1'b0;

    // Single beat with tag 3 and latency 2.
    mem[64'h100] = 64'h00000005_FFFFFFFF;
    run_op(64'h100, 1, 0, 2, 0, 4'd3, 0);
    check("t1_stored", mem[64'h100], 64'hFFFFFFFB_00000001);
    check("t1_neg_cycles_lanes1", last_neg, 3);

    // Three beats starting at address 0.
    run_op(64'h0, 3, 0, 1, 0, 4'd5, 0);

    // The first LOAD is refused four times before acceptance.
    run_op(64'h200, 1, 4, 1, 0, 4'd1, 0);

    // A stray tag arrives in LD_WAIT; the extreme lane values pass unchanged.
    mem[64'h300] = 64'h80000000_00000000;
    run_op(64'h300, 1, 0, 3, 1, 4'd2, 0);
    check("t4_stored", mem[64'h300], 64'h80000000_00000000);

    // NEG_LANES=2 instance with the same data as the first case.
    sel = 1'b1;
    mem[64'h100] = 64'h00000005_FFFFFFFF;
    run_op(64'h100, 1, 0, 2, 0, 4'd3, 0);
    check("t5_stored_lanes2", mem[64'h100], 64'hFFFFFFFB_00000001);
    check("t5_neg_cycles_lanes2", last_neg, 2);
    sel = 1'b0;

    // Zero beats: done one cycle after start.
    run_op(64'h500, 0, 0, 1, 0, 4'd1, 0);
    check("t6_zero_beats_latency", last_cycles, 1);

    // Reset while in ST_WAIT.
    run_op(64'h400, 2, 0, 2, 0, 4'd4, 1);

    // Address wrap on the second beat.
    run_op(64'hFFFF_FFFF_FFFF_FFF8, 2, 0, 1, 0, 4'd6, 0);
    check("t8_wrap_addr", last_ld_addr, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
